// File: rtl/bus_arbiter_if.sv
// Motherboard/CPU arbitration signals; all strobes are active low except EXTOWN and TIMEOUT.
// master = board and CPU side driving requests, slave = the arbiter driving grants.
interface bus_arbiter_if;
  logic BR;
  logic BGACK;
  logic AS;
  logic AS20;
  logic BG20;
  logic BR20;
  logic BG;
  logic EXTOWN;
  logic TIMEOUT;

  modport master (
    output BR, BGACK, AS, AS20, BG20,
    input  BR20, BG, EXTOWN, TIMEOUT
  );

  modport slave (
    input  BR, BGACK, AS, AS20, BG20,
    output BR20, BG, EXTOWN, TIMEOUT
  );
endinterface

// File: rtl/bus_arbiter.sv
// 68000 BR/BG/BGACK arbiter sharing the motherboard bus between the CPU and external masters.
// Optional grant timeout enabled by defining BUS_ARBITER_TIMEOUT_EN.
module bus_arbiter #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic          CLKCPU,
  input logic          RESET,
  bus_arbiter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, REQ, GRANT, OWNED, RELEASE} state_t;

  logic [SYNC_STAGES-1:0] br_sync;
  logic [SYNC_STAGES-1:0] bgack_sync;
  logic [SYNC_STAGES-1:0] as_sync;
  logic                   br_s;
  logic                   bgack_s;
  logic                   as_s;
  state_t                 state;
  state_t                 nxt;
  logic                   tmo_hit;
  logic                   tmo_fire;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("bus_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  // Synchronisers idle high so a reset never looks like a request.
  always_ff @(posedge CLKCPU or negedge RESET) begin
    if (!RESET) begin
      br_sync    <= '1;
      bgack_sync <= '1;
      as_sync    <= '1;
    end else begin
      br_sync    <= SYNC_STAGES'({br_sync, bus.BR});
      bgack_sync <= SYNC_STAGES'({bgack_sync, bus.BGACK});
      as_sync    <= SYNC_STAGES'({as_sync, bus.AS});
    end
  end

  assign br_s    = br_sync[SYNC_STAGES-1];
  assign bgack_s = bgack_sync[SYNC_STAGES-1];
  assign as_s    = as_sync[SYNC_STAGES-1];

`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] tmo_cnt;

  always_ff @(posedge CLKCPU or negedge RESET) begin
    if (!RESET) begin
      tmo_cnt <= '0;
    end else if (nxt == GRANT && state != GRANT) begin
      tmo_cnt <= '0;
    end else if (state == GRANT) begin
      tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end

  assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    nxt      = state;
    tmo_fire = 1'b0;
    case (state)
      IDLE: begin
        if (!bgack_s)   nxt = OWNED;
        else if (!br_s) nxt = REQ;
      end
      REQ: begin
        if (!bus.BG20 && bus.AS20 && as_s) nxt = GRANT;
        else if (br_s)                     nxt = RELEASE;
      end
      GRANT: begin
        if (!bgack_s) begin
          nxt = OWNED;
        end else if (br_s) begin
          nxt = RELEASE;
        end else if (tmo_hit) begin
          nxt      = RELEASE;
          tmo_fire = 1'b1;
        end
      end
      OWNED: begin
        // A second master queued behind the first gets the bus without the CPU waking.
        if (bgack_s) nxt = br_s ? RELEASE : GRANT;
      end
      RELEASE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLKCPU or negedge RESET) begin
    if (!RESET) begin
      state       <= IDLE;
      bus.BR20    <= 1'b1;
      bus.BG      <= 1'b1;
      bus.EXTOWN  <= 1'b0;
      bus.TIMEOUT <= 1'b0;
    end else begin
      state       <= nxt;
      bus.BR20    <= (nxt == IDLE) || (nxt == RELEASE);
      bus.BG      <= (nxt != GRANT);
      bus.EXTOWN  <= (nxt == OWNED);
      bus.TIMEOUT <= tmo_fire;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a per-cycle vector table plus hand-written multi-cycle sequences.
module tb_bus_arbiter;
  localparam int TMO = 8;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  bus_arbiter_if bus_if();

  bus_arbiter #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TMO)) dut (
    .CLKCPU (clk),
    .RESET  (rst_n),
    .bus    (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // inputs: br bgack as as20 bg20 | expected: br20 bg extown timeout
  typedef struct packed {
    logic br, bgack, as_m, as20, bg20;
    logic br20, bg, ext, tmo;
  } vec_t;

  vec_t vecs [20];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic br, input logic bgack, input logic as_m,
                       input logic as20, input logic bg20);
    bus_if.BR    = br;
    bus_if.BGACK = bgack;
    bus_if.AS    = as_m;
    bus_if.AS20  = as20;
    bus_if.BG20  = bg20;
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  logic flag;

  initial begin
    vecs[0]  = 9'b01111_1100;
    vecs[1]  = 9'b01111_1100;
    vecs[2]  = 9'b01111_0100;
    vecs[3]  = 9'b01111_0100;
    vecs[4]  = 9'b01110_0000;
    vecs[5]  = 9'b00110_0000;
    vecs[6]  = 9'b00110_0000;
    vecs[7]  = 9'b00110_0110;
    vecs[8]  = 9'b00010_0110;
    vecs[9]  = 9'b11111_0110;
    vecs[10] = 9'b11111_0110;
    vecs[11] = 9'b11111_1100;
    vecs[12] = 9'b11111_1100;
    vecs[13] = 9'b00111_1100;
    vecs[14] = 9'b00111_1100;
    vecs[15] = 9'b00111_0110;
    vecs[16] = 9'b11111_0110;
    vecs[17] = 9'b11111_0110;
    vecs[18] = 9'b11111_1100;
    vecs[19] = 9'b11111_1100;

    // Reset held with BR asserted
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step(); step(); step();
    chk("rst_br20", bus_if.BR20, 1'b1);
    chk("rst_bg", bus_if.BG, 1'b1);
    chk("rst_extown", bus_if.EXTOWN, 1'b0);
    chk("rst_timeout", bus_if.TIMEOUT, 1'b0);
    rst_n = 1'b1;
    step();
    chk("req_edge0_br20", bus_if.BR20, 1'b1);
    step();
    chk("req_edge1_br20", bus_if.BR20, 1'b1);
    step();
    chk("req_edge2_br20", bus_if.BR20, 1'b0);
    step(); step(); step();
    chk("req_no_bg20_bg", bus_if.BG, 1'b1);

    // Request withdrawn while in REQ
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step(); step();
    chk("withdraw_still_req", bus_if.BR20, 1'b0);
    step();
    chk("withdraw_release_br20", bus_if.BR20, 1'b1);
    step(); step(); step();
    chk("withdraw_idle_br20", bus_if.BR20, 1'b1);

    // Vector table: full tenure, then simultaneous BR/BGACK from idle
    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].br, vecs[i].bgack, vecs[i].as_m, vecs[i].as20, vecs[i].bg20);
      step();
      chk($sformatf("vec%0d_br20", i), bus_if.BR20, vecs[i].br20);
      chk($sformatf("vec%0d_bg", i), bus_if.BG, vecs[i].bg);
      chk($sformatf("vec%0d_extown", i), bus_if.EXTOWN, vecs[i].ext);
      chk($sformatf("vec%0d_timeout", i), bus_if.TIMEOUT, vecs[i].tmo);
    end

    // Busy CPU bus delays the grant
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step(); step(); step();
    chk("busy_req_br20", bus_if.BR20, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("busy_bg_c%0d", i), bus_if.BG, 1'b1);
    end
    bus_if.AS20 = 1'b1;
    step();
    chk("busy_bg_after_as20", bus_if.BG, 1'b0);

    // Back-to-back masters: CPU stays held throughout
    bus_if.BGACK = 1'b0;
    step(); step(); step();
    chk("b2b_owned_extown", bus_if.EXTOWN, 1'b1);
    chk("b2b_owned_bg", bus_if.BG, 1'b1);
    bus_if.BGACK = 1'b1;
    flag = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus_if.BR20 !== 1'b0) flag = 1'b1;
    end
    chk("b2b_regrant_bg", bus_if.BG, 1'b0);
    chk("b2b_regrant_extown", bus_if.EXTOWN, 1'b0);
    chk("b2b_br20_stayed_low", flag, 1'b0);

`ifdef BUS_ARBITER_TIMEOUT_EN
    flag = 1'b0;
    for (int i = 1; i < TMO; i++) begin
      step();
      if (bus_if.BG !== 1'b0 || bus_if.TIMEOUT !== 1'b0) flag = 1'b1;
    end
    chk("tmo_grant_held", flag, 1'b0);
    step();
    chk("tmo_pulse", bus_if.TIMEOUT, 1'b1);
    chk("tmo_release_bg", bus_if.BG, 1'b1);
    chk("tmo_release_br20", bus_if.BR20, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    chk("tmo_pulse_end", bus_if.TIMEOUT, 1'b0);
    step(); step(); step();
    chk("tmo_settled_br20", bus_if.BR20, 1'b1);
`else
    flag = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (bus_if.BG !== 1'b0 || bus_if.TIMEOUT !== 1'b0) flag = 1'b1;
    end
    chk("notmo_grant_held_100", flag, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step(); step(); step();
    chk("notmo_release_bg", bus_if.BG, 1'b1);
    chk("notmo_release_br20", bus_if.BR20, 1'b1);
    step(); step();
`endif

    // Asynchronous reset during an external tenure
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    step(); step(); step();
    chk("arst_owned_extown", bus_if.EXTOWN, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_br20", bus_if.BR20, 1'b1);
    chk("arst_bg", bus_if.BG, 1'b1);
    chk("arst_extown", bus_if.EXTOWN, 1'b0);
    bus_if.BGACK = 1'b1;
    step(); step();
    rst_n = 1'b1;
    step(); step(); step();
    chk("arst_after_idle_br20", bus_if.BR20, 1'b1);
    chk("arst_after_idle_extown", bus_if.EXTOWN, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
